// File: rtl/wash_billing_if.sv
`default_nettype none
// ============================================================================
//  Module      : wash_billing_if
//  Description : Button, wash-stage and display signals of the payment front-end.
//                Optional refund port pair under WASH_BILLING_REFUND_EN.
//  Revision    : 1.0  initial release
// ============================================================================
interface wash_billing_if;
    logic       coin1;
    logic       coin5;
    logic       start;
    logic       done;
    logic [9:0] bal;
    logic       on;
    logic       err;
`ifdef WASH_BILLING_REFUND_EN
    logic       refund;
    logic [9:0] refund_val;

    modport master (
        output coin1, coin5, start, done, refund,
        input  bal, on, err, refund_val
    );
    modport slave (
        input  coin1, coin5, start, done, refund,
        output bal, on, err, refund_val
    );
`else
    modport master (
        output coin1, coin5, start, done,
        input  bal, on, err
    );
    modport slave (
        input  coin1, coin5, start, done,
        output bal, on, err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/wash_billing.sv
`default_nettype none
// ============================================================================
//  Module      : wash_billing
//  Description : Coin/start button conditioning, saturating balance and wash
//                billing FSM. Optional refund button under WASH_BILLING_REFUND_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module wash_billing #(
    parameter int DB_CYCLES  = 2_000_000,
    parameter int PRICE      = 15,
    parameter int BAL_MAX    = 999,
    parameter int ERR_CYCLES = 100_000_000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    wash_billing_if.slave   bus
);

    localparam int          c_DBW     = $clog2(DB_CYCLES + 1);
    localparam int          c_ERW     = $clog2(ERR_CYCLES + 1);
    localparam logic [10:0] c_PRICE   = 11'(PRICE);
    localparam logic [10:0] c_BAL_MAX = 11'(BAL_MAX);
    localparam logic [10:0] c_FIVE    = 11'd5;

`ifdef WASH_BILLING_REFUND_EN
    localparam int c_NIN = 4;
`else
    localparam int c_NIN = 3;
`endif

    localparam int c_COIN1  = 0;
    localparam int c_COIN5  = 1;
    localparam int c_START  = 2;

    logic [c_NIN-1:0] w_raw;
    logic [c_NIN-1:0] w_pulse;

    assign w_raw[c_COIN1] = bus.coin1;
    assign w_raw[c_COIN5] = bus.coin5;
    assign w_raw[c_START] = bus.start;
`ifdef WASH_BILLING_REFUND_EN
    assign w_raw[3]       = bus.refund;
`endif

    // Per-button chain: 2-flop sync, counting debouncer, registered rising-edge pulse.
    for (genvar gi = 0; gi < c_NIN; gi++) begin : g_cond
        logic [1:0]       r_sync;
        logic             r_db;
        logic             r_db_q;
        logic             r_pulse;
        logic [c_DBW-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync  <= 2'b00;
                r_db    <= 1'b0;
                r_db_q  <= 1'b0;
                r_pulse <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync  <= {r_sync[0], w_raw[gi]};
                r_db_q  <= r_db;
                r_pulse <= r_db & ~r_db_q;
                if (r_sync[1] != r_db) begin
                    if (r_cnt == c_DBW'(DB_CYCLES - 1)) begin
                        r_db  <= r_sync[1];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DBW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_pulse[gi] = r_pulse;
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WASH = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [9:0]       r_bal;
    logic [9:0]       w_bal_nxt;
    logic [c_ERW-1:0] r_ecnt;
    logic [c_ERW-1:0] w_ecnt_nxt;
    logic             r_on;
    logic             r_err;
    logic [10:0]      w_charge;
    logic [10:0]      w_sum;
    logic             w_funded;

`ifdef WASH_BILLING_REFUND_EN
    logic [9:0]       r_refund_val;
    logic [9:0]       w_refund_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_bal   <= '0;
            r_ecnt  <= '0;
            r_on    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bal   <= w_bal_nxt;
            r_ecnt  <= w_ecnt_nxt;
            r_on    <= (w_state_nxt == S_WASH);
            r_err   <= (w_state_nxt == S_ERR);
        end
    end

`ifdef WASH_BILLING_REFUND_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refund_val <= '0;
        end else begin
            r_refund_val <= w_refund_nxt;
        end
    end
`endif

    // Price check uses the balance before this cycle's coins.
    assign w_funded = ({1'b0, r_bal} >= c_PRICE);

    always_comb begin
        w_state_nxt = r_state;
        w_ecnt_nxt  = r_ecnt;
        w_charge    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pulse[c_START]) begin
                    if (w_funded) begin
                        w_state_nxt = S_WASH;
                        w_charge    = c_PRICE;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_ecnt_nxt  = c_ERW'(ERR_CYCLES - 1);
                    end
                end
            end
            S_WASH: begin
                if (bus.done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                if (r_ecnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ecnt_nxt = r_ecnt - c_ERW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ecnt_nxt  = '0;
            end
        endcase

        // Charge never exceeds the balance, so 11 bits cannot underflow or overflow.
        w_sum = {1'b0, r_bal} - w_charge
              + {10'd0, w_pulse[c_COIN1]}
              + (w_pulse[c_COIN5] ? c_FIVE : 11'd0);
        w_bal_nxt = (w_sum > c_BAL_MAX) ? c_BAL_MAX[9:0] : w_sum[9:0];

`ifdef WASH_BILLING_REFUND_EN
        // Refund in IDLE empties the balance, drops same-cycle coins and outranks start.
        w_refund_nxt = r_refund_val;
        if (w_pulse[3] && (r_state == S_IDLE)) begin
            w_refund_nxt = r_bal;
            w_bal_nxt    = '0;
            w_state_nxt  = S_IDLE;
            w_ecnt_nxt   = r_ecnt;
        end
`endif
    end

    assign bus.bal = r_bal;
    assign bus.on  = r_on;
    assign bus.err = r_err;
`ifdef WASH_BILLING_REFUND_EN
    assign bus.refund_val = r_refund_val;
`endif

endmodule
`default_nettype wire
